// File: rtl/nios2_gen2_0_cpu_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the Avalon debug_mem_slave and the
// JTAG debug-slave command path; owns JTAG address auto-increment and write protection.
module nios2_gen2_0_cpu_ocimem_arbiter #(
  parameter logic [7:0] PROT_BASE = 8'hE0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [31:0] av_writedata,
  input  logic [3:0]  av_byteenable,
  input  logic        av_debugaccess,
  output logic [31:0] av_readdata,
  output logic        av_waitrequest,
  input  logic        jtag_ld_addr,
  input  logic [7:0]  jtag_addr,
  input  logic        jtag_rd_req,
  input  logic        jtag_wr_req,
  input  logic [31:0] jtag_wdata,
  output logic [31:0] MonDReg,
  output logic        jtag_ack,
  output logic        jtag_busy,
  output logic        jtag_overrun,
  output logic [7:0]  ram_addr,
  output logic        ram_wren,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rddata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE} state_t;

  state_t      state;
  logic [7:0]  mon_areg;
  logic        pend_vld;
  logic        pend_wr;
  logic [7:0]  pend_addr;
  logic [31:0] pend_wdata;
  logic        ptr_jtag;
  logic        own_jtag;
  logic        op_wr;

  logic        jtag_pulse;
  logic        av_req;
  logic        grant_jtag;

  function automatic logic av_wr_allowed(input logic [7:0] addr, input logic dbg);
    return (addr < PROT_BASE) || dbg;
  endfunction

  assign jtag_pulse = jtag_rd_req | jtag_wr_req;
  assign av_req     = (av_read | av_write) & av_waitrequest;
  // JTAG wins when it holds the pointer or when Avalon is not asking.
  assign grant_jtag = pend_vld & (ptr_jtag | ~av_req);
  // pend_vld stays set from latch until DONE, so it covers pending and in-service.
  assign jtag_busy  = pend_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      mon_areg       <= 8'h00;
      pend_vld       <= 1'b0;
      pend_wr        <= 1'b0;
      pend_addr      <= 8'h00;
      pend_wdata     <= 32'h0;
      ptr_jtag       <= 1'b1;
      own_jtag       <= 1'b0;
      op_wr          <= 1'b0;
      av_readdata    <= 32'h0;
      av_waitrequest <= 1'b1;
      MonDReg        <= 32'h0;
      jtag_ack       <= 1'b0;
      jtag_overrun   <= 1'b0;
      ram_addr       <= 8'h00;
      ram_wren       <= 1'b0;
      ram_be         <= 4'h0;
      ram_wdata      <= 32'h0;
    end else begin
      if (jtag_ld_addr)
        mon_areg <= jtag_addr;
      else if (state == ST_DONE && own_jtag)
        mon_areg <= mon_areg + 8'd1;

      if (jtag_pulse) begin
        if (pend_vld) begin
          jtag_overrun <= 1'b1;
        end else begin
          pend_vld   <= 1'b1;
          pend_wr    <= jtag_wr_req;
          pend_addr  <= jtag_ld_addr ? jtag_addr : mon_areg;
          pend_wdata <= jtag_wdata;
        end
      end

      case (state)
        ST_IDLE: begin
          if (pend_vld | av_req) begin
            state    <= ST_ACCESS;
            own_jtag <= grant_jtag;
            ptr_jtag <= ~grant_jtag;
            if (grant_jtag) begin
              op_wr     <= pend_wr;
              ram_addr  <= pend_addr;
              ram_be    <= 4'hF;
              ram_wdata <= pend_wdata;
              ram_wren  <= pend_wr;
            end else begin
              op_wr     <= av_write;
              ram_addr  <= av_address;
              ram_be    <= av_byteenable;
              ram_wdata <= av_writedata;
              ram_wren  <= av_write & av_wr_allowed(av_address, av_debugaccess);
            end
          end
        end
        ST_ACCESS: begin
          ram_wren <= 1'b0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!op_wr) begin
            if (own_jtag) MonDReg     <= ram_rddata;
            else          av_readdata <= ram_rddata;
          end
          if (own_jtag) jtag_ack       <= 1'b1;
          else          av_waitrequest <= 1'b0;
          state <= ST_DONE;
        end
        ST_DONE: begin
          jtag_ack       <= 1'b0;
          av_waitrequest <= 1'b1;
          // A pulse arriving in this cycle already saw pend_vld and was dropped.
          if (own_jtag) pend_vld <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nios2_gen2_0_cpu_ocimem_arbiter.md
# nios2_gen2_0_cpu_ocimem_arbiter

Arbiter and sequencer for the Nios II on-chip-instrumentation (OCI) debug RAM. It shares one single-port RAM between two requesters. The first is the CPU's Avalon debug_mem_slave side. The second is the JTAG debug-slave command side, which arrives as sysclk-domain action pulses carrying decoded jdo fields. It sits in the sysclk domain, downstream of the debug-slave sysclk decoder, and owns JTAG address auto-increment, write protection and the read-data return paths.

## Interface
Parameters:
- PROT_BASE, 8'hE0: first word address of the protected region; Avalon writes at or above it need debugaccess=1.

Ports:
- clk  in  1  system clock; all state is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- av_address  in  8  Avalon word address.
- av_read  in  1  Avalon read request.
- av_write  in  1  Avalon write request.
- av_writedata  in  32  Avalon write data.
- av_byteenable  in  4  Avalon byte enables.
- av_debugaccess  in  1  privileged access qualifier.
- av_readdata  out  32  Avalon read data; valid while av_waitrequest=0.
- av_waitrequest  out  1  Avalon stall.
- jtag_ld_addr  in  1  pulse: load the JTAG address register from jtag_addr.
- jtag_addr  in  8  address field from jdo.
- jtag_rd_req  in  1  pulse: JTAG read at the current JTAG address.
- jtag_wr_req  in  1  pulse: JTAG write of jtag_wdata at the current JTAG address.
- jtag_wdata  in  32  write-data field from jdo.
- MonDReg  out  32  last JTAG read data.
- jtag_ack  out  1  one-cycle pulse when a JTAG access completes.
- jtag_busy  out  1  a JTAG request is pending or in service.
- jtag_overrun  out  1  sticky: a JTAG request was dropped.
- ram_addr  out  8  RAM address.
- ram_wren  out  1  RAM write enable.
- ram_be  out  4  RAM byte enables.
- ram_wdata  out  32  RAM write data.
- ram_rddata  in  32  RAM read data; one-cycle registered latency.

## Operation
- Reset values:
  - av_waitrequest=1; every other output is 0.
  - Pending JTAG request is cleared; JTAG address register (MonAReg) is 0.
  - Round-robin pointer favours JTAG.
- JTAG front end:
  - jtag_ld_addr sets MonAReg to jtag_addr.
  - A rd or wr pulse latches a pending request {wr, MonAReg, jtag_wdata}. If ld_addr arrives in the same cycle, the pending request takes the new jtag_addr.
  - Both rd and wr pulsing together count as a write.
  - A rd/wr pulse while a request is already pending or in service is dropped and sets jtag_overrun. jtag_overrun clears only on reset.
  - MonAReg increments at the DONE of every JTAG access (wraps 8'hFF to 8'h00). A simultaneous ld_addr takes priority over the increment.
- Avalon front end:
  - A request is av_read or av_write high while av_waitrequest=1.
  - If both are high, it is treated as a write.
  - Address and data are sampled at grant; the master holds them per Avalon rules.
- FSM:
  - IDLE: if any request exists, grant one requester and go to ACCESS.
    - If both request, the pointer holder wins.
    - The pointer then moves to the other requester.
  - ACCESS: drive ram_addr, ram_be, ram_wdata and ram_wren for one cycle, then go to WAIT.
    - JTAG byte enables are 4'hF.
    - ram_wren=0 for reads.
    - ram_wren=0 for an Avalon write with av_address>=PROT_BASE and av_debugaccess=0; the access still completes normally.
  - WAIT: for a read, register ram_rddata into av_readdata or MonDReg. Then go to DONE.
  - DONE:
    - Avalon owner: av_waitrequest=0 for exactly this cycle.
    - JTAG owner: jtag_ack=1 and the pending request is cleared.
    - Next state is IDLE.
- All ram_* outputs are registered. ram_wren is high only in ACCESS.
- av_readdata and MonDReg hold their value until the next read by the same owner.

## Timing
- Request visible in IDLE at cycle T0:
  - ram_wren/ram_addr in T1.
  - Data registered at end of T2.
  - av_waitrequest=0 or jtag_ack=1 in T3.
  - IDLE again in T4.
- The JTAG pulse latch adds one cycle: a pulse at Tp becomes the pending request at Tp+1, which is T0.
- Minimum access period is 4 cycles. Under contention each requester is served within 8 cycles of becoming pending.
- A losing request stays pending with no loss. The Avalon master keeps av_waitrequest=1 throughout.
- Reset asserted mid-access:
  - Immediate return to reset values; ram_wren drops asynchronously.
  - No ack or waitrequest release is issued for the aborted access.

## Test plan
- Reset, then Avalon write addr 8'h10, data 32'hCAFEF00D, be 4'hF; read back -> ram_wren high once in T1; av_waitrequest low only in T3; readback av_readdata=32'hCAFEF00D.
- jtag_ld_addr with 8'hFF, then jtag_wr_req 32'h1 and jtag_wr_req 32'h2 spaced 6 cycles -> writes land at 8'hFF then 8'h00; two jtag_ack pulses; MonAReg=8'h01.
- Avalon read and JTAG read first pending in the same cycle after reset -> JTAG granted first, Avalon next; back-to-back with no idle gap beyond IDLE.
- Avalon write to 8'hE4 with debugaccess=0, then with debugaccess=1 -> first: ram_wren stays 0 and waitrequest still releases; second: RAM written.
- Second jtag_rd_req 1 cycle after the first -> jtag_overrun=1; exactly one jtag_ack.
- reset_n low during WAIT of an Avalon read -> av_waitrequest=1, ram_wren=0, state IDLE; re-issued read completes in 4 cycles.
